// File: rtl/ysyx_23060077_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// ysyx_23060077_axi_rd_arbiter : two-master (ICache / LSU) AXI read arbiter.
// Optional macro YSYX_23060077_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Revision 1.0
// ============================================================================
module ysyx_23060077_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              icache_r_valid_i,
    input  logic [ADDR_W-1:0] icache_r_addr_i,
    input  logic [LEN_W-1:0]  icache_r_len_i,
    output logic              icache_r_ready_o,
    output logic [DATA_W-1:0] icache_r_data_o,
    output logic              icache_r_last_o,

    input  logic              lsu_r_valid_i,
    input  logic [ADDR_W-1:0] lsu_r_addr_i,
    input  logic [LEN_W-1:0]  lsu_r_len_i,
    input  logic [2:0]        lsu_r_size_i,
    output logic              lsu_r_ready_o,
    output logic [DATA_W-1:0] lsu_r_data_o,
    output logic              lsu_r_last_o,

    output logic              axi_arvalid_o,
    output logic [ADDR_W-1:0] axi_araddr_o,
    output logic [LEN_W-1:0]  axi_arlen_o,
    output logic [2:0]        axi_arsize_o,
    output logic [3:0]        axi_arid_o,
    input  logic              axi_arready_i,

    input  logic              axi_rvalid_i,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic              axi_rlast_i,
    output logic              axi_rready_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [2:0] ICACHE_SIZE = 3'b010;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;      // 1 = LSU owns the bus
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [2:0]          size_q,  size_d;
    logic                grant_lsu;

`ifdef YSYX_23060077_ARB_ROUND_ROBIN_EN
    logic                last_lsu_q, last_lsu_d;

    // On a tie the requester that did not win last time goes first.
    assign grant_lsu = lsu_r_valid_i & (~icache_r_valid_i | ~last_lsu_q);
`else
    assign grant_lsu = lsu_r_valid_i;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
`ifdef YSYX_23060077_ARB_ROUND_ROBIN_EN
        last_lsu_d = last_lsu_q;
`endif
        case (state_q)
            IDLE: begin
                // Requests are level-sensitive: anything raised while busy is seen here.
                if (icache_r_valid_i || lsu_r_valid_i) begin
                    state_d = ADDR;
                    owner_d = grant_lsu;
                    addr_d  = grant_lsu ? lsu_r_addr_i : icache_r_addr_i;
                    len_d   = grant_lsu ? lsu_r_len_i  : icache_r_len_i;
                    size_d  = grant_lsu ? lsu_r_size_i : ICACHE_SIZE;
`ifdef YSYX_23060077_ARB_ROUND_ROBIN_EN
                    last_lsu_d = grant_lsu;
`endif
                end
            end
            ADDR: begin
                if (axi_arready_i) state_d = DATA;
            end
            DATA: begin
                if (axi_rvalid_i && axi_rlast_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
`ifdef YSYX_23060077_ARB_ROUND_ROBIN_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
`ifdef YSYX_23060077_ARB_ROUND_ROBIN_EN
            last_lsu_q <= last_lsu_d;
`endif
        end
    end

    logic in_addr, in_data, route_icache, route_lsu;

    assign in_addr      = (state_q == ADDR);
    assign in_data      = (state_q == DATA);
    assign route_icache = in_data & ~owner_q;
    assign route_lsu    = in_data &  owner_q;

    assign axi_arvalid_o = in_addr;
    assign axi_araddr_o  = in_addr ? addr_q : '0;
    assign axi_arlen_o   = in_addr ? len_q  : '0;
    assign axi_arsize_o  = in_addr ? size_q : 3'b000;
    assign axi_arid_o    = {3'b000, in_addr & owner_q};
    assign axi_rready_o  = in_data;

    assign icache_r_ready_o = route_icache & axi_rvalid_i;
    assign icache_r_data_o  = route_icache ? axi_rdata_i : '0;
    assign icache_r_last_o  = route_icache & axi_rvalid_i & axi_rlast_i;

    assign lsu_r_ready_o    = route_lsu & axi_rvalid_i;
    assign lsu_r_data_o     = route_lsu ? axi_rdata_i : '0;
    assign lsu_r_last_o     = route_lsu & axi_rvalid_i & axi_rlast_i;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060077_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ysyx_23060077_axi_rd_arbiter : directed self-checking bench for the arbiter.
// Revision 1.0
// ============================================================================
module tb_ysyx_23060077_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        icache_r_valid_i = 1'b0;
    logic [31:0] icache_r_addr_i  = '0;
    logic [7:0]  icache_r_len_i   = '0;
    logic        icache_r_ready_o;
    logic [31:0] icache_r_data_o;
    logic        icache_r_last_o;
    logic        lsu_r_valid_i = 1'b0;
    logic [31:0] lsu_r_addr_i  = '0;
    logic [7:0]  lsu_r_len_i   = '0;
    logic [2:0]  lsu_r_size_i  = '0;
    logic        lsu_r_ready_o;
    logic [31:0] lsu_r_data_o;
    logic        lsu_r_last_o;
    logic        axi_arvalid_o;
    logic [31:0] axi_araddr_o;
    logic [7:0]  axi_arlen_o;
    logic [2:0]  axi_arsize_o;
    logic [3:0]  axi_arid_o;
    logic        axi_arready_i = 1'b0;
    logic        axi_rvalid_i  = 1'b0;
    logic [31:0] axi_rdata_i   = '0;
    logic        axi_rlast_i   = 1'b0;
    logic        axi_rready_o;

    int tests = 0;
    int fails = 0;

    logic [116:0] all_out;
    assign all_out = {axi_arvalid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arid_o,
                      axi_rready_o, icache_r_ready_o, icache_r_data_o, icache_r_last_o,
                      lsu_r_ready_o, lsu_r_data_o, lsu_r_last_o};

    ysyx_23060077_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clock(clock), .reset(reset),
        .icache_r_valid_i(icache_r_valid_i), .icache_r_addr_i(icache_r_addr_i),
        .icache_r_len_i(icache_r_len_i), .icache_r_ready_o(icache_r_ready_o),
        .icache_r_data_o(icache_r_data_o), .icache_r_last_o(icache_r_last_o),
        .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
        .lsu_r_len_i(lsu_r_len_i), .lsu_r_size_i(lsu_r_size_i),
        .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o),
        .lsu_r_last_o(lsu_r_last_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o),
        .axi_arlen_o(axi_arlen_o), .axi_arsize_o(axi_arsize_o),
        .axi_arid_o(axi_arid_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i),
        .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
    );

    always #5 clock = ~clock;

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1;
        #1;
        tests++;
        if ({axi_rready_o, icache_r_ready_o, lsu_r_ready_o} !== 3'b000) begin
            fails++; $display("FAIL reset_stray_r: got %b expected 000", {axi_rready_o, icache_r_ready_o, lsu_r_ready_o});
        end
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL post_reset_idle: got %h expected 0", all_out); end
    endtask

    task automatic test_icache_single();
        step();
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0010; icache_r_len_i = 8'd0;
        @(negedge clock);
        tests++;
        if (axi_arvalid_o !== 1'b0) begin fails++; $display("FAIL ic_arvalid_cycle_n: got %b expected 0", axi_arvalid_o); end
        step();
        icache_r_valid_i = 1'b0; axi_arready_i = 1'b1;
        @(negedge clock);
        tests++;
        if (axi_arvalid_o !== 1'b1) begin fails++; $display("FAIL ic_arvalid_n1: got %b expected 1", axi_arvalid_o); end
        tests++;
        if (axi_araddr_o !== 32'h3000_0010) begin fails++; $display("FAIL ic_araddr: got %h expected 30000010", axi_araddr_o); end
        tests++;
        if ({axi_arid_o, axi_arsize_o, axi_arlen_o} !== {4'd0, 3'b010, 8'd0}) begin
            fails++; $display("FAIL ic_arid_size_len: got %h expected %h", {axi_arid_o, axi_arsize_o, axi_arlen_o}, {4'd0, 3'b010, 8'd0});
        end
        tests++;
        if (axi_rready_o !== 1'b0) begin fails++; $display("FAIL ic_rready_in_addr: got %b expected 0", axi_rready_o); end
        step();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rdata_i = 32'hDEAD_BEEF; axi_rlast_i = 1'b1;
        @(negedge clock);
        tests++;
        if ({axi_rready_o, icache_r_ready_o, icache_r_last_o, lsu_r_ready_o} !== 4'b1110) begin
            fails++; $display("FAIL ic_beat_flags: got %b expected 1110", {axi_rready_o, icache_r_ready_o, icache_r_last_o, lsu_r_ready_o});
        end
        tests++;
        if (icache_r_data_o !== 32'hDEAD_BEEF || lsu_r_data_o !== 32'h0) begin
            fails++; $display("FAIL ic_beat_data: got %h/%h expected deadbeef/0", icache_r_data_o, lsu_r_data_o);
        end
        step();
        @(negedge clock);
        tests++;
        if ({axi_arvalid_o, axi_rready_o, icache_r_ready_o} !== 3'b000) begin
            fails++; $display("FAIL ic_back_idle: got %b expected 000", {axi_arvalid_o, axi_rready_o, icache_r_ready_o});
        end
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
    endtask

    task automatic test_fixed_priority();
        step();
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0020; icache_r_len_i = 8'd0;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0100; lsu_r_len_i = 8'd0; lsu_r_size_i = 3'b000;
        step();
        lsu_r_valid_i = 1'b0; axi_arready_i = 1'b1;
        @(negedge clock);
        tests++;
        if ({axi_arvalid_o, axi_araddr_o, axi_arsize_o, axi_arid_o} !== {1'b1, 32'h8000_0100, 3'b000, 4'd1}) begin
            fails++; $display("FAIL prio_first_ar: got %h expected %h", {axi_arvalid_o, axi_araddr_o, axi_arsize_o, axi_arid_o},
                              {1'b1, 32'h8000_0100, 3'b000, 4'd1});
        end
        step();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1; axi_rdata_i = 32'h1111_2222;
        @(negedge clock);
        tests++;
        if ({lsu_r_ready_o, lsu_r_last_o, lsu_r_data_o, icache_r_ready_o, icache_r_data_o} !== {2'b11, 32'h1111_2222, 1'b0, 32'h0}) begin
            fails++; $display("FAIL prio_lsu_beat: got %h expected %h", {lsu_r_ready_o, lsu_r_last_o, lsu_r_data_o, icache_r_ready_o, icache_r_data_o},
                              {2'b11, 32'h1111_2222, 1'b0, 32'h0});
        end
        step();
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        @(negedge clock);
        tests++;
        if (axi_arvalid_o !== 1'b0) begin fails++; $display("FAIL prio_idle_gap: got %b expected 0", axi_arvalid_o); end
        step();
        icache_r_valid_i = 1'b0; axi_arready_i = 1'b1;
        @(negedge clock);
        tests++;
        if ({axi_arvalid_o, axi_araddr_o, axi_arsize_o, axi_arid_o} !== {1'b1, 32'h3000_0020, 3'b010, 4'd0}) begin
            fails++; $display("FAIL prio_second_ar: got %h expected %h", {axi_arvalid_o, axi_araddr_o, axi_arsize_o, axi_arid_o},
                              {1'b1, 32'h3000_0020, 3'b010, 4'd0});
        end
        step();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1;
        step();
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_id [4];
        int n;
`ifdef YSYX_23060077_ARB_ROUND_ROBIN_EN
        exp_id = '{1, 0, 1, 0};
`else
        exp_id = '{1, 1, 1, 1};
`endif
        step();
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0100;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0180; lsu_r_size_i = 3'b010;
        axi_arready_i = 1'b1; axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1; axi_rdata_i = 32'h0BAD_F00D;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            @(negedge clock);
            while (!axi_arvalid_o && n < 8) begin
                @(negedge clock);
                n++;
            end
            tests++;
            if (axi_arvalid_o !== 1'b1 || axi_arid_o !== exp_id[t][3:0]) begin
                fails++; $display("FAIL rr_grant_%0d: got arvalid=%b arid=%0d expected arvalid=1 arid=%0d", t, axi_arvalid_o, axi_arid_o, exp_id[t]);
            end
            if (t == 3) begin
                icache_r_valid_i = 1'b0; lsu_r_valid_i = 1'b0;
            end
        end
        step();
        step();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        @(negedge clock);
        tests++;
        if ({axi_arvalid_o, axi_rready_o} !== 2'b00) begin
            fails++; $display("FAIL rr_final_idle: got %b expected 00", {axi_arvalid_o, axi_rready_o});
        end
    endtask

    task automatic test_lsu_burst();
        logic [6:0] pat;
        int pulses;
        int lasts;
        pat = 7'b1100101;
        pulses = 0; lasts = 0;
        step();
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0200; lsu_r_len_i = 8'd3; lsu_r_size_i = 3'b010;
        step();
        lsu_r_valid_i = 1'b0; lsu_r_addr_i = 32'hFFFF_FFFF; axi_arready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tests++;
            if ({axi_arvalid_o, axi_araddr_o, axi_arlen_o} !== {1'b1, 32'h8000_0200, 8'd3}) begin
                fails++; $display("FAIL burst_ar_hold_%0d: got %h expected %h", k, {axi_arvalid_o, axi_araddr_o, axi_arlen_o}, {1'b1, 32'h8000_0200, 8'd3});
            end
        end
        axi_arready_i = 1'b1;
        step();
        axi_arready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            axi_rvalid_i = pat[i]; axi_rlast_i = (i == 6); axi_rdata_i = 32'hA000_0000 + i;
            @(negedge clock);
            if (lsu_r_ready_o === 1'b1) begin
                pulses++;
                tests++;
                if (lsu_r_data_o !== 32'hA000_0000 + i) begin
                    fails++; $display("FAIL burst_data_%0d: got %h expected %h", i, lsu_r_data_o, 32'hA000_0000 + i);
                end
            end
            if (lsu_r_last_o === 1'b1) begin
                lasts++;
                tests++;
                if (pulses != 4) begin fails++; $display("FAIL burst_last_pos: got beat %0d expected 4", pulses); end
            end
            tests++;
            if (icache_r_ready_o !== 1'b0) begin fails++; $display("FAIL burst_ic_leak_%0d: got %b expected 0", i, icache_r_ready_o); end
            step();
        end
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        tests++;
        if (pulses != 4 || lasts != 1) begin fails++; $display("FAIL burst_counts: got %0d/%0d expected 4/1", pulses, lasts); end
        @(negedge clock);
        tests++;
        if (axi_rready_o !== 1'b0) begin fails++; $display("FAIL burst_idle: got %b expected 0", axi_rready_o); end
    endtask

    task automatic test_back_to_back();
        step();
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0040; icache_r_len_i = 8'd0;
        step();
        icache_r_valid_i = 1'b0; axi_arready_i = 1'b1;
        step();
        axi_arready_i = 1'b0;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0300; lsu_r_len_i = 8'd0; lsu_r_size_i = 3'b001;
        axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1; axi_rdata_i = 32'hCAFE_0001;
        @(negedge clock);
        tests++;
        if ({icache_r_ready_o, lsu_r_ready_o, lsu_r_data_o} !== {2'b10, 32'h0}) begin
            fails++; $display("FAIL b2b_owner_only: got %h expected %h", {icache_r_ready_o, lsu_r_ready_o, lsu_r_data_o}, {2'b10, 32'h0});
        end
        step();
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        step();
        lsu_r_valid_i = 1'b0;
        @(negedge clock);
        tests++;
        if ({axi_arvalid_o, axi_araddr_o, axi_arsize_o, axi_arid_o} !== {1'b1, 32'h8000_0300, 3'b001, 4'd1}) begin
            fails++; $display("FAIL b2b_pending_ar: got %h expected %h", {axi_arvalid_o, axi_araddr_o, axi_arsize_o, axi_arid_o},
                              {1'b1, 32'h8000_0300, 3'b001, 4'd1});
        end
        axi_arready_i = 1'b1;
        step();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1;
        step();
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0400; lsu_r_len_i = 8'd3; lsu_r_size_i = 3'b010;
        step();
        lsu_r_valid_i = 1'b0; axi_arready_i = 1'b1;
        step();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rlast_i = 1'b0; axi_rdata_i = 32'h5555_0001;
        @(negedge clock);
        tests++;
        if (lsu_r_ready_o !== 1'b1) begin fails++; $display("FAIL rstmid_beat1: got %b expected 1", lsu_r_ready_o); end
        step();
        axi_rvalid_i = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL rstmid_async: got %h expected 0", all_out); end
        step();
        reset = 1'b1;
        axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++;
            if ({axi_arvalid_o, axi_rready_o, icache_r_ready_o, lsu_r_ready_o, lsu_r_last_o} !== 5'b0) begin
                fails++; $display("FAIL rstmid_stray_%0d: got %b expected 00000", c,
                                  {axi_arvalid_o, axi_rready_o, icache_r_ready_o, lsu_r_ready_o, lsu_r_last_o});
            end
        end
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_icache_single();
        test_fixed_priority();
        test_round_robin();
        test_lsu_burst();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
